// File: rtl/raster_streamer.sv
// Raster stream source: buffers upstream {sof, pixel} words and replays them against free-running
// frame counters, resynchronising on underflow or misplaced start-of-frame. Option: RASTER_PATTERN_EN.
module raster_streamer #(
  parameter int BIT_WIDTH    = 8,
  parameter int IMAGE_HEIGHT = 480,
  parameter int IMAGE_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 525,
  parameter int FRAME_WIDTH  = 800,
  parameter int FIFO_DEPTH   = 16,
  parameter int V_BITW       = $clog2(FRAME_HEIGHT),
  parameter int H_BITW       = $clog2(FRAME_WIDTH)
) (
  input  logic                 clock,
  input  logic                 n_rst,
  input  logic [BIT_WIDTH-1:0] in_pixel,
  input  logic                 in_sof,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BIT_WIDTH-1:0] out_pixel,
  output logic [V_BITW-1:0]    out_vcnt,
  output logic [H_BITW-1:0]    out_hcnt,
  output logic                 out_locked,
  output logic                 underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {SYNC = 1'b0, STREAM = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [H_BITW-1:0]    hc_q, hc_d;
  logic [V_BITW-1:0]    vc_q, vc_d;
  logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [BIT_WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [BIT_WIDTH-1:0] out_pixel_q, out_pixel_d;
  logic [V_BITW-1:0]    out_vcnt_q;
  logic [H_BITW-1:0]    out_hcnt_q;
  logic                 out_locked_q, out_locked_d;

  logic                 full_s, empty_s, push_s, pop_s, uf_s;
  logic                 active_s, origin_s, head_sof_s;
  logic [BIT_WIDTH-1:0] head_pix_s, pattern_s;
  logic [BIT_WIDTH:0]   head_s;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign full_s     = ((wr_q - rd_q) == PW'(FIFO_DEPTH));
  assign empty_s    = (wr_q == rd_q);
  assign push_s     = in_valid & ~full_s;
  assign in_ready   = ~full_s;
  assign head_s     = mem_q[rd_q[AW-1:0]];
  assign head_sof_s = head_s[BIT_WIDTH];
  assign head_pix_s = head_s[BIT_WIDTH-1:0];
  assign active_s   = (vc_q < V_BITW'(IMAGE_HEIGHT)) && (hc_q < H_BITW'(IMAGE_WIDTH));
  assign origin_s   = (vc_q == '0) && (hc_q == '0);

`ifdef RASTER_PATTERN_EN
  logic [V_BITW+H_BITW-1:0] sum_s;
  assign sum_s     = {{H_BITW{1'b0}}, vc_q} + {{V_BITW{1'b0}}, hc_q};
  assign pattern_s = BIT_WIDTH'(sum_s);
`else
  assign pattern_s = '0;
`endif

  assign out_pixel  = out_pixel_q;
  assign out_vcnt   = out_vcnt_q;
  assign out_hcnt   = out_hcnt_q;
  assign out_locked = out_locked_q;
  assign underflow  = uf_s;

  // Free-running horizontal/vertical frame counters.
  always_comb begin
    hc_d = hc_q + H_BITW'(1);
    vc_d = vc_q;
    if (hc_q == H_BITW'(FRAME_WIDTH - 1)) begin
      hc_d = '0;
      if (vc_q == V_BITW'(FRAME_HEIGHT - 1)) begin
        vc_d = '0;
      end else begin
        vc_d = vc_q + V_BITW'(1);
      end
    end else begin
      hc_d = hc_q + H_BITW'(1);
    end
  end

  // Lock state machine: decides pops, the next output pixel and resync events.
  always_comb begin
    state_d     = state_q;
    pop_s       = 1'b0;
    uf_s        = 1'b0;
    out_pixel_d = '0;
    case (state_q)
      SYNC: begin
        out_pixel_d = active_s ? pattern_s : '0;
        if (empty_s) begin
          state_d = SYNC;
        end else if (!head_sof_s) begin
          pop_s = 1'b1;
        end else if (origin_s) begin
          pop_s       = 1'b1;
          out_pixel_d = head_pix_s;
          state_d     = STREAM;
        end else begin
          state_d = SYNC;
        end
      end
      STREAM: begin
        if (!active_s) begin
          state_d = STREAM;
        end else if (empty_s) begin
          uf_s    = 1'b1;
          state_d = SYNC;
        end else if (head_sof_s && !origin_s) begin
          state_d = SYNC;
        end else begin
          pop_s       = 1'b1;
          out_pixel_d = head_pix_s;
        end
      end
      default: state_d = SYNC;
    endcase
    out_locked_d = (state_d == STREAM);
    wr_d = wr_q + (push_s ? PW'(1) : PW'(0));
    rd_d = rd_q + (pop_s ? PW'(1) : PW'(0));
  end

  // FIFO storage; contents need no reset since the pointers gate every read.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[wr_q[AW-1:0]] <= {in_sof, in_pixel};
    end
  end

  // State, counters, pointers and registered stream outputs.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= SYNC;
      hc_q         <= '0;
      vc_q         <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      out_pixel_q  <= '0;
      out_vcnt_q   <= '0;
      out_hcnt_q   <= '0;
      out_locked_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hc_q         <= hc_d;
      vc_q         <= vc_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      out_pixel_q  <= out_pixel_d;
      out_vcnt_q   <= vc_q;
      out_hcnt_q   <= hc_q;
      out_locked_q <= out_locked_d;
    end
  end

endmodule

// File: tb/tb_raster_streamer.sv
// Directed bench for raster_streamer on a 4x4 image in a 6x6 frame with an 8-entry FIFO.
module tb_raster_streamer;
  localparam int IH = 4, IW = 4, FH = 6, FW = 6, FD = 8, FS = FH * FW;

  logic       clock = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] in_pixel = 8'd0;
  logic       in_sof = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_pixel;
  logic [2:0] out_vcnt, out_hcnt;
  logic       out_locked, underflow;

  int checks = 0, errors = 0, pos = 0, rdy_low_run = 0;
  logic [8:0] feed_q[$];

  raster_streamer #(
    .BIT_WIDTH(8), .IMAGE_HEIGHT(IH), .IMAGE_WIDTH(IW),
    .FRAME_HEIGHT(FH), .FRAME_WIDTH(FW), .FIFO_DEPTH(FD)
  ) dut (
    .clock(clock), .n_rst(n_rst), .in_pixel(in_pixel), .in_sof(in_sof),
    .in_valid(in_valid), .in_ready(in_ready), .out_pixel(out_pixel),
    .out_vcnt(out_vcnt), .out_hcnt(out_hcnt), .out_locked(out_locked),
    .underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s pos=%0d got %0d expected %0d", tag, pos, obs, exp);
    end
  endtask

  function automatic int sync_pix(input int v, input int h);
    if (v < IH && h < IW) begin
`ifdef RASTER_PATTERN_EN
      return (v + h) % 256;
`else
      return 0;
`endif
    end
    return 0;
  endfunction

  // One clock: present the next upstream word, check underflow before the edge, outputs after.
  task automatic step(input int exp_pix, input int exp_lk, input int exp_uf);
    int v, h;
    logic fire;
    v = (pos % FS) / FW;
    h = pos % FW;
    if (feed_q.size() > 0) begin
      in_valid = 1'b1;
      {in_sof, in_pixel} = feed_q[0];
    end else begin
      in_valid = 1'b0;
    end
    fire = in_valid & in_ready;
    if (in_ready) rdy_low_run = 0;
    else rdy_low_run++;
    check_eq("underflow", int'(underflow), exp_uf);
    @(posedge clock);
    #1;
    if (fire) void'(feed_q.pop_front());
    check_eq("vcnt", int'(out_vcnt), v);
    check_eq("hcnt", int'(out_hcnt), h);
    check_eq("pixel", int'(out_pixel), exp_pix);
    check_eq("locked", int'(out_locked), exp_lk);
    pos++;
  endtask

  task automatic enqueue_frame(input int base, input int n, input int sof2);
    for (int i = 0; i < n; i++) begin
      feed_q.push_back({(i == 0 || i == sof2) ? 1'b1 : 1'b0, 8'(base + i)});
    end
  endtask

  task automatic sync_frame();
    for (int c = 0; c < FS; c++) begin
      step(sync_pix((pos % FS) / FW, pos % FW), 0, 0);
    end
  endtask

  // Frame locked at (0,0) emitting base+index until frame position stop_k, where it drops to SYNC.
  task automatic stream_frame(input int base, input int stop_k, input int stop_uf, input int next_base);
    for (int c = 0; c < FS; c++) begin
      int k, v, h;
      k = pos % FS;
      v = k / FW;
      h = k % FW;
      if (k < stop_k) begin
        step((v < IH && h < IW) ? base + v * IW + h : 0, 1, 0);
      end else if (k == stop_k) begin
        step(0, 0, stop_uf);
        if (next_base > 0) enqueue_frame(next_base, 16, 8);
      end else begin
        step(sync_pix(v, h), 0, 0);
      end
    end
  endtask

  task automatic release_reset();
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_rst = 1'b1;
    pos = 0;
  endtask

  initial begin
    release_reset();
    check_eq("rst_ready", int'(in_ready), 1);
    check_eq("rst_pixel", int'(out_pixel), 0);
    check_eq("rst_locked", int'(out_locked), 0);

    // Idle: two frames of counters only.
    sync_frame();
    sync_frame();

    // Preload and lock; tail words continue into the short next frame.
    enqueue_frame(1, 16, -1);
    enqueue_frame(101, 10, -1);
    sync_frame();
    check_eq("full_ready", int'(in_ready), 0);
    stream_frame(1, FS, 0, 0);

    // Short frame: underflow at (2,2), then a frame with sof on pixel 9.
    stream_frame(101, 14, 1, 201);
    stream_frame(201, 12, 0, 0);
    stream_frame(209, 12, 1, 0);

    // Junk without sof drains one per cycle.
    rdy_low_run = 0;
    for (int i = 0; i < 24; i++) feed_q.push_back({1'b0, 8'(8'h50 + i)});
    for (int i = 0; i < 24; i++) begin
      step(sync_pix((pos % FS) / FW, pos % FW), 0, 0);
      check_eq("rdy_run", int'(rdy_low_run > 1), 0);
    end

    // Reset mid-frame clears outputs immediately.
    in_valid = 1'b0;
    n_rst = 1'b0;
    #1;
    check_eq("mid_rst_pixel", int'(out_pixel), 0);
    check_eq("mid_rst_vcnt", int'(out_vcnt), 0);
    check_eq("mid_rst_hcnt", int'(out_hcnt), 0);
    check_eq("mid_rst_locked", int'(out_locked), 0);
    check_eq("mid_rst_uf", int'(underflow), 0);
    check_eq("mid_rst_ready", int'(in_ready), 1);
    release_reset();
    enqueue_frame(51, 16, -1);
    sync_frame();
    stream_frame(51, FS, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/raster_streamer.md
Name: raster_streamer

Overview:
Source end of the raster pixel stream (pixel, vcnt, hcnt) that every filter in the pipeline consumes.
- Accepts pixels from an upstream valid/ready producer (camera/DMA), tagged with start-of-frame.
- Buffers them in a small FIFO.
- Emits them in raster order against free-running frame counters, including blanking.
- Re-synchronises automatically on underflow or misplaced start-of-frame.

Parameters:
BIT_WIDTH, 8, pixel width.
IMAGE_HEIGHT, 480, active lines per frame.
IMAGE_WIDTH, 640, active pixels per line.
FRAME_HEIGHT, 525, total lines incl. blanking; V_BITW = ceil(log2(FRAME_HEIGHT)).
FRAME_WIDTH, 800, total pixels per line incl. blanking; H_BITW = ceil(log2(FRAME_WIDTH)).
FIFO_DEPTH, 16, input FIFO entries; power of two, >= 2.

Ports:
clock  in  1  system clock.
n_rst  in  1  asynchronous active-low reset.
in_pixel  in  BIT_WIDTH  upstream pixel.
in_sof  in  1  marks first pixel of a frame.
in_valid  in  1  upstream data valid.
in_ready  out  1  FIFO can accept; equals not-full.
out_pixel  out  BIT_WIDTH  stream pixel (registered).
out_vcnt  out  V_BITW  line count of out_pixel (registered).
out_hcnt  out  H_BITW  column count of out_pixel (registered).
out_locked  out  1  high while in STREAM state (registered).
underflow  out  1  one-cycle pulse when an active pixel is due and the FIFO is empty.

Behaviour:
Reset (n_rst low, asynchronous):
- Counters, FIFO pointers and all outputs go to 0.
- State = SYNC.
- in_ready is 1 the first cycle after release.

Counters (hc, vc):
- Free-run every cycle.
- hc wraps FRAME_WIDTH-1 -> 0 and increments vc; vc wraps FRAME_HEIGHT-1 -> 0.
- Active region: vc < IMAGE_HEIGHT and hc < IMAGE_WIDTH.

Output timing:
- All stream outputs are registered, 1-cycle latency: out_vcnt/out_hcnt = previous cycle's vc/hc.
- out_pixel = 0 outside the active region, and in SYNC state.

FIFO:
- Push on in_valid & in_ready; stores {in_sof, in_pixel}.
- No bypass: a word pushed in cycle t is poppable at t+1 at the earliest.
- Push and pop in the same cycle allowed when not empty and not full.

State machine (SYNC, STREAM):
- SYNC:
  - Head present with sof=0: pop and discard, one per cycle.
  - Head with sof=1: hold.
  - At (vc,hc) = (0,0) with an sof=1 head: pop it, output it, go to STREAM.
- STREAM: on each active (vc,hc), the first matching case applies:
  1. FIFO empty: out_pixel = 0, underflow pulses, go to SYNC.
  2. Head sof=1 and (vc,hc) != (0,0): do not pop, output 0, go to SYNC (head kept as the next frame start).
  3. Otherwise: pop and output the head pixel.
- Blanking cycles never pop.
- Transition into STREAM at (0,0) and any pop occur in the same cycle.

Other rules:
- out_locked = (state == STREAM), registered alongside the stream outputs.
- in_ready depends only on FIFO fullness, never on in_valid (no combinational path).
- Full FIFO with in_valid high: no push, data held upstream.

Optional Feature:
Macro RASTER_PATTERN_EN.
- Defined: in SYNC state, active-region out_pixel = (vc + hc) truncated to BIT_WIDTH (diagonal ramp) so downstream blocks and displays show a known pattern while unlocked.
- Undefined: SYNC active pixels output 0.
- Blanking output is 0 in both cases.

Test Plan:
(Parameters for all: IMAGE 4x4, FRAME 6x6, FIFO_DEPTH 8.)
1. Reset release, no input -> out_locked=0, out_pixel=0 for 2 full frames; out_hcnt cycles 0..5 and out_vcnt 0..5 with 1-cycle lag; underflow never asserts.
2. Preload 16 pixels 1..16 (sof on 1) before (0,0) -> locked from (0,0); active out_pixel = 1..16 in raster order; blanking = 0; out_locked=1.
3. Supply only 10 pixels of a frame -> pixels 1..10 out, underflow pulses exactly once at (2,2), out_locked falls the next cycle, rest of frame = 0.
4. Frame of 16 where pixel 9 carries sof=1 -> 1..8 out, then 0 and SYNC at (2,0); relock at next (0,0) outputting the retained pixel 9 first.
5. in_valid held high with no locking (no sof) -> FIFO drains junk one per cycle; in_ready never stays low more than 1 cycle; after reset mid-frame all outputs are 0 immediately, then the bench relocks as in scenario 2.
6. RASTER_PATTERN_EN defined, no input -> active pixel at out (vcnt=2, hcnt=3) = 5; blanking = 0.
